// File: rtl/tdm_mux_8x1.sv
// tdm_mux_8x1 -- eight-channel time-division multiplexer (transmit side).
//
// At frame start the eight channel words and the enable mask are captured;
// the enabled channels are then sent one per accepted slot in ascending
// index order, with the channel index on s for the receiving 1x8 demux.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   en         run request, sampled only when a frame may start
//   mask[7:0]  channel enables, captured at frame start
//   d[8*W-1:0] channel words, channel i at d[i*W +: W], captured at frame start
//   ready      downstream accepts the current slot
//   y[W-1:0]   current slot word (registered)
//   s[2:0]     current slot channel index (registered)
//   valid      y/s hold a slot
//   sof        current slot is the first of its frame
//   busy       a frame is in progress
//   frame_cnt  completed-frame count, wraps at 256
module tdm_mux_8x1 #(
    parameter int unsigned W = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic [7:0]     mask,
    input  logic [8*W-1:0] d,
    input  logic           ready,
    output logic [W-1:0]   y,
    output logic [2:0]     s,
    output logic           valid,
    output logic           sof,
    output logic           busy,
    output logic [7:0]     frame_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t         state;
    logic [8*W-1:0] sh;
    logic [7:0]     mask_q;

    logic           start;
    logic [2:0]     first_idx;
    logic [2:0]     next_idx;
    logic [W-1:0]   first_word;
    logic [W-1:0]   next_word;

    function automatic logic [2:0] lowest(input logic [7:0] v);
        logic [2:0] idx;
        logic       found;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (v[i] && !found) begin
                idx   = 3'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

    function automatic logic [W-1:0] word(input logic [8*W-1:0] v, input logic [2:0] idx);
        logic [W-1:0] w;
        w = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (idx == 3'(i)) begin
                w = v[i*W +: W];
            end
        end
        return w;
    endfunction

    always_comb begin
        start      = en & (|mask);
        first_idx  = lowest(mask);
        first_word = word(d, first_idx);
        next_idx   = lowest(mask_q);
        next_word  = word(sh, next_idx);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sh        <= '0;
            mask_q    <= '0;
            y         <= '0;
            s         <= '0;
            valid     <= 1'b0;
            sof       <= 1'b0;
            busy      <= 1'b0;
            frame_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sh     <= d;
                        s      <= first_idx;
                        y      <= first_word;
                        mask_q <= mask & ~(8'd1 << first_idx);
                        valid  <= 1'b1;
                        sof    <= 1'b1;
                        busy   <= 1'b1;
                        state  <= SEND;
                    end else begin
                        valid <= 1'b0;
                        sof   <= 1'b0;
                    end
                end
                SEND: begin
                    if (valid && ready) begin
                        if (mask_q != '0) begin
                            s      <= next_idx;
                            y      <= next_word;
                            mask_q <= mask_q & ~(8'd1 << next_idx);
                            sof    <= 1'b0;
                        end else begin
                            frame_cnt <= frame_cnt + 8'd1;
                            // Last slot accepted: chain straight into the
                            // next frame when possible so there is no bubble.
                            if (start) begin
                                sh     <= d;
                                s      <= first_idx;
                                y      <= first_word;
                                mask_q <= mask & ~(8'd1 << first_idx);
                                sof    <= 1'b1;
                            end else begin
                                valid <= 1'b0;
                                sof   <= 1'b0;
                                busy  <= 1'b0;
                                state <= IDLE;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tdm_mux_8x1.sv
// Testbench for tdm_mux_8x1 (W=4). A slot-queue reference model predicts
// every output after each rising edge; each scenario task compares inline.
module tb_tdm_mux_8x1;

    localparam int unsigned W  = 4;
    localparam int unsigned VW = 14 + W;

    logic           clk;
    logic           rst_n;
    logic           en;
    logic [7:0]     mask;
    logic [8*W-1:0] d;
    logic           ready;
    logic [W-1:0]   y;
    logic [2:0]     s;
    logic           valid;
    logic           sof;
    logic           busy;
    logic [7:0]     frame_cnt;

    tdm_mux_8x1 #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .mask      (mask),
        .d         (d),
        .ready     (ready),
        .y         (y),
        .s         (s),
        .valid     (valid),
        .sof       (sof),
        .busy      (busy),
        .frame_cnt (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // ---------------- reference model ----------------
    typedef struct {
        logic [2:0]   ch;
        logic [W-1:0] word;
    } slot_t;

    slot_t        pend[$];
    logic         m_valid;
    logic         m_sof;
    logic [2:0]   m_s;
    logic [W-1:0] m_y;
    int           m_cnt;

    task automatic model_reset();
        pend.delete();
        m_valid = 1'b0;
        m_sof   = 1'b0;
        m_s     = '0;
        m_y     = '0;
        m_cnt   = 0;
    endtask

    // Builds the frame's slot list from the captured mask/words, then
    // presents the first slot.
    task automatic model_start();
        slot_t sl;
        pend.delete();
        for (int i = 0; i < 8; i++) begin
            if (mask[i]) begin
                sl.ch   = 3'(i);
                sl.word = d[i*W +: W];
                pend.push_back(sl);
            end
        end
        sl      = pend.pop_front();
        m_s     = sl.ch;
        m_y     = sl.word;
        m_valid = 1'b1;
        m_sof   = 1'b1;
    endtask

    task automatic model_edge();
        slot_t sl;
        bit    go;
        go = en && (mask != 8'h00);
        if (!m_valid) begin
            if (go) model_start();
            else m_sof = 1'b0;
        end else if (ready) begin
            if (pend.size() > 0) begin
                sl    = pend.pop_front();
                m_s   = sl.ch;
                m_y   = sl.word;
                m_sof = 1'b0;
            end else begin
                m_cnt = (m_cnt + 1) % 256;
                if (go) model_start();
                else begin
                    m_valid = 1'b0;
                    m_sof   = 1'b0;
                end
            end
        end
    endtask

    function automatic logic [VW-1:0] dut_vec();
        return {valid, sof, busy, s, y, frame_cnt};
    endfunction

    function automatic logic [VW-1:0] mdl_vec();
        return {m_valid, m_sof, m_valid, m_s, m_y, 8'(m_cnt)};
    endfunction

    // Advance one clock; model follows the inputs present at the edge.
    task automatic cycle();
        @(posedge clk);
        if (rst_n) model_edge();
        cyc++;
        #1;
    endtask

    function automatic logic [8*W-1:0] rand_d();
        return (8*W)'({$urandom, $urandom});
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        en = 0; mask = '0; d = '0; ready = 1;
        rst_n = 0;
        model_reset();
        #13;
        checks++;
        if (dut_vec() !== '0) begin
            errors++;
            $display("FAIL reset_state got=%h exp=%h", dut_vec(), {VW{1'b0}});
        end
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_basic();
        logic [7:0]   bits;
        logic [2:0]   exp_s[8];
        logic [W-1:0] exp_y[8];
        bits = 8'b1010_0110;
        for (int i = 0; i < 8; i++) begin
            d[i*W +: W] = W'(bits[i]);
        end
        mask = 8'hFF; ready = 1; en = 1;
        cycle();
        en = 0;
        for (int i = 0; i < 8; i++) begin
            exp_s[i] = 3'(i);
            exp_y[i] = W'(bits[i]);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (dut_vec() !== mdl_vec() || s !== exp_s[i] || y !== exp_y[i] ||
                sof !== (i == 0) || valid !== 1'b1) begin
                errors++;
                $display("FAIL basic slot=%0d got s=%0d y=%h sof=%b v=%b exp s=%0d y=%h", i, s, y, sof, valid, exp_s[i], exp_y[i]);
            end
            cycle();
        end
        checks++;
        if (valid !== 1'b0 || busy !== 1'b0 || frame_cnt !== 8'd1) begin
            errors++;
            $display("FAIL basic_end got v=%b busy=%b cnt=%0d exp v=0 busy=0 cnt=1", valid, busy, frame_cnt);
        end
    endtask

    task automatic test_sparse();
        logic [2:0]   exp_s[3];
        logic [W-1:0] exp_y[3];
        exp_s[0] = 3'd1; exp_s[1] = 3'd4; exp_s[2] = 3'd7;
        exp_y[0] = 4'h9; exp_y[1] = 4'hC; exp_y[2] = 4'hF;
        for (int i = 0; i < 8; i++) d[i*W +: W] = W'(i + 8);
        mask = 8'b1001_0010; ready = 1; en = 1;
        cycle();
        en = 0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (dut_vec() !== mdl_vec() || s !== exp_s[i] || y !== exp_y[i]) begin
                errors++;
                $display("FAIL sparse slot=%0d got s=%0d y=%h exp s=%0d y=%h", i, s, y, exp_s[i], exp_y[i]);
            end
            d = rand_d(); mask = 8'($urandom);
            cycle();
        end
        checks++;
        if (valid !== 1'b0 || dut_vec() !== mdl_vec()) begin
            errors++;
            $display("FAIL sparse_end got=%h exp=%h", dut_vec(), mdl_vec());
        end
    endtask

    task automatic test_backpressure();
        logic [2:0]   hs;
        logic [W-1:0] hy;
        int           guard;
        d = rand_d(); mask = 8'hFF; ready = 1; en = 1;
        cycle();
        en = 0;
        guard = 0;
        while (s !== 3'd2 && guard < 20) begin
            cycle();
            guard++;
        end
        checks++;
        if (s !== 3'd2) begin
            errors++;
            $display("FAIL bp_reach got s=%0d exp s=2", s);
        end
        hs = 3'd2; hy = d[2*W +: W];
        ready = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++;
            if (dut_vec() !== mdl_vec() || s !== hs || y !== hy || valid !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold cyc=%0d got s=%0d y=%h v=%b exp s=%0d y=%h v=1", i, s, y, valid, hs, hy);
            end
        end
        ready = 1;
        cycle();
        checks++;
        if (dut_vec() !== mdl_vec() || s !== 3'd3) begin
            errors++;
            $display("FAIL bp_release got s=%0d exp s=3", s);
        end
        repeat (6) cycle();
    endtask

    task automatic test_continuous();
        bit saw_wrap;
        logic [7:0] prev;
        saw_wrap = 0;
        mask = 8'h03; ready = 1; en = 1; d = rand_d();
        prev = frame_cnt;
        for (int i = 0; i < 560; i++) begin
            cycle();
            if (prev == 8'd255 && frame_cnt == 8'd0) saw_wrap = 1;
            prev = frame_cnt;
            checks++;
            if (dut_vec() !== mdl_vec() || valid !== 1'b1 || s !== 3'(i % 2)) begin
                errors++;
                $display("FAIL continuous i=%0d got=%h exp=%h", i, dut_vec(), mdl_vec());
            end
            d = rand_d();
        end
        checks++;
        if (!saw_wrap) begin
            errors++;
            $display("FAIL cnt_wrap got=no_wrap exp=wrap_255_to_0");
        end
        en = 0;
        repeat (3) cycle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            en    = ($urandom_range(0, 3) != 0);
            mask  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            d     = rand_d();
            ready = ($urandom_range(0, 3) != 0);
            cycle();
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++;
                $display("FAIL random cyc=%0d got=%h exp=%h", cyc, dut_vec(), mdl_vec());
            end
        end
        en = 0; ready = 1;
        repeat (10) cycle();
    endtask

    task automatic test_zero_mask();
        en = 1; mask = 8'h00; ready = 1; d = rand_d();
        for (int i = 0; i < 8; i++) begin
            cycle();
            checks++;
            if (valid !== 1'b0 || busy !== 1'b0 || dut_vec() !== mdl_vec()) begin
                errors++;
                $display("FAIL zero_mask i=%0d got v=%b busy=%b exp v=0 busy=0", i, valid, busy);
            end
        end
        en = 0;
    endtask

    task automatic test_reset_mid();
        rst_n = 0; #7; model_reset();
        @(negedge clk); rst_n = 1;
        d = rand_d(); mask = 8'hFF; ready = 1; en = 1;
        cycle();
        en = 0;
        repeat (3) cycle();
        checks++;
        if (valid !== 1'b1 || dut_vec() !== mdl_vec()) begin
            errors++;
            $display("FAIL rst_mid_pre got=%h exp=%h", dut_vec(), mdl_vec());
        end
        #3;
        rst_n = 0;
        model_reset();
        #1;
        checks++;
        if (dut_vec() !== '0) begin
            errors++;
            $display("FAIL rst_mid_async got=%h exp=%h", dut_vec(), {VW{1'b0}});
        end
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            checks++;
            if (dut_vec() !== '0) begin
                errors++;
                $display("FAIL rst_mid_after i=%0d got=%h exp=%h", i, dut_vec(), {VW{1'b0}});
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sparse();
        test_backpressure();
        test_continuous();
        test_random();
        test_zero_mask();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/tdm_mux_8x1.md
# tdm_mux_8x1

Eight-channel time-division multiplexer: the transmit end of the 1-to-8 select/demultiplex path. At each frame start it snapshots eight channel words and a channel-enable mask. It then presents the enabled channels one per accepted slot, in ascending index order, on a single output together with the 3-bit channel select `s`. That select drives a 1x8 demultiplexer at the receiving end. A valid/ready handshake paces the stream, and a frame counter tracks completed frames.

## Interface

Parameters:
- `W`, 1, width of each channel word and of `y`.

Ports:
- `clk`  input  1  single clock; all logic on its rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `en`  input  1  run request; sampled only when a new frame can start.
- `mask`  input  8  channel enable; bit i enables channel i; sampled with `d` at frame start.
- `d`  input  8*W  channel words; channel i occupies `d[i*W +: W]`; sampled at frame start.
- `ready`  input  1  downstream accepts the current slot this cycle.
- `y`  output  W  current slot's channel word (registered).
- `s`  output  3  current slot's channel index (registered).
- `valid`  output  1  `y`/`s` hold a slot.
- `sof`  output  1  high while the current slot is the first slot of a frame.
- `busy`  output  1  high in SEND.
- `frame_cnt`  output  8  count of completed frames; wraps 255 -> 0.

## Operation

- The state machine has two states: IDLE and SEND.
- Internal registers:
  - shadow `sh` (8*W bits) holds the frame's channel words.
  - `mask_q` (8 bits) holds the channels still pending in the current frame.
- Frame start condition: `en & (|mask)`. It is evaluated in IDLE, and in SEND on the accepting edge of a frame's last slot.
- At frame start:
  - `sh <= d`.
  - Let `m` be the lowest set bit of `mask`. Set `s <= m`, `y <= d[m]`, `mask_q <= mask` with bit `m` cleared.
  - Set `valid <= 1`, `sof <= 1`, state -> SEND.
- IDLE without the frame start condition:
  - `valid = 0`, `sof = 0`; all other outputs hold.
  - `en=1` with `mask=0` stays in IDLE (no empty frames).
- SEND with `valid & !ready`: `y`, `s`, `sof` and `mask_q` hold stable.
- SEND with `valid & ready` (slot accepted):
  - If `mask_q != 0`: let `m` be the lowest set bit of `mask_q`. Set `s <= m`, `y <= sh[m]`, clear bit `m` of `mask_q`, `sof <= 0`.
  - If `mask_q == 0` (last slot accepted): `frame_cnt <= frame_cnt + 1`, modulo 256. Then either start the next frame on the same edge (frame start condition true, no bubble), or set `valid <= 0`, `sof <= 0`, state -> IDLE.
- Changes to `en`, `mask` or `d` during SEND have no effect on the current frame. Dropping `en` mid-frame does not truncate the frame.
- A single-channel mask produces a one-slot frame: `sof=1` on that slot.
- Channels are emitted strictly in ascending index order. Disabled channels take no slot.

## Timing

- Reset (async assert, `rst_n=0`): all outputs and internal registers go to 0; state -> IDLE. That is `y=0`, `s=0`, `valid=0`, `sof=0`, `busy=0`, `frame_cnt=0`.
- Release is synchronous to `clk`. The first frame can start on the first rising edge with `rst_n=1`.
- Latency: frame start condition true before edge N gives `valid=1` with the first slot after edge N (1 cycle).
- Throughput: one slot per cycle while `ready=1`. A frame with k enabled channels occupies exactly k accepting cycles. Back-to-back frames have no idle cycle.
- `frame_cnt` updates on the edge that accepts a frame's last slot.
- Reset asserted mid-frame aborts the frame immediately. The frame is not counted and no slot is replayed after release.

## Test plan

- Basic frame (`W=1`):
  - Stimulus: reset, then `mask=8'hFF`, `d=8'b1010_0110`, `ready=1`, `en` pulsed for 1 cycle.
  - Required: 8 slots with `s=0..7` and `y=0,1,1,0,0,1,0,1`; `sof` only on `s=0`; `frame_cnt=1`; IDLE afterwards.
- Sparse mask:
  - Stimulus: `mask=8'b1001_0010`, `W=4`, channel words `d[i]=i+4'h8`.
  - Required: slots `(s,y)=(1,9),(4,C),(7,F)`; then `valid=0`.
- Backpressure:
  - Stimulus: `ready=0` for 3 cycles on slot `s=2`.
  - Required: `y`, `s` and `valid=1` stable for all 3 cycles; slot `s=3` follows the cycle after `ready` returns high.
- Continuous run:
  - Stimulus: `en=1` held, `mask=8'h03`, `ready=1`, `d` changed mid-frame.
  - Required: slots `s=0,1,0,1,...` with no gap; changed `d` appears only in the next frame; `frame_cnt` 255 -> 0 wrap observed.
- Zero mask and reset:
  - Stimulus: `en=1` with `mask=0`. Then, in a separate run, `rst_n` driven low mid-frame.
  - Required: `en=1`, `mask=0` never raises `valid`. Reset mid-frame clears all outputs to 0 asynchronously, and `frame_cnt` stays 0.
